// File: rtl/conv_mac_accumulator_pkg.sv
// Shared constants and helpers for the LeNet accumulate/rescale datapath.
// Used by the conv accumulator and the fully-connected layer.
package lenet_acc_pkg;
   localparam int DWIDTH = 16;
   localparam int PWIDTH = 32;
   localparam int ACC_W  = 40;
   localparam int FRAC   = 15;

   localparam logic [DWIDTH-1:0] Q_MAX = 16'h7FFF;
   localparam logic [DWIDTH-1:0] Q_MIN = 16'h8000;

   // Counter width for n states; never below 1 so NTAPS=1 still has a register.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction
endpackage

// File: rtl/conv_mac_accumulator_if.sv
// Tap input stream and result output stream of the conv accumulator.
interface conv_mac_accumulator_if;
   import lenet_acc_pkg::*;

   logic [PWIDTH-1:0] p_in;
   logic              p_valid;
   logic              p_ready;
   logic [DWIDTH-1:0] bias_in;
   logic [DWIDTH-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              busy;

   modport master (
      output p_in, p_valid, bias_in, dout_ready,
      input  p_ready, dout, dout_valid, busy
   );

   modport slave (
      input  p_in, p_valid, bias_in, dout_ready,
      output p_ready, dout, dout_valid, busy
   );
endinterface

// File: rtl/conv_mac_accumulator_acc_rescale_sat.sv
// Combinational Q2.30-sum to Q1.15 rescale (floor shift) with saturation.
// Define CONV_ACC_RELU_EN to clamp negative results to zero after saturation.
module acc_rescale_sat
   import lenet_acc_pkg::*;
(
   input  logic signed [ACC_W-1:0]  sum,
   output logic        [DWIDTH-1:0] res
);
   localparam int RW = ACC_W - FRAC;

   logic [RW-1:0]        r;
   logic [RW-DWIDTH:0]   hi;
   logic [DWIDTH-1:0]    sat;

   // Arithmetic shift gives the same bits as slicing [30:15] of a product.
   assign r  = RW'(sum >>> FRAC);
   assign hi = r[RW-1:DWIDTH-1];

   always_comb begin
      sat = r[DWIDTH-1:0];
      if (!((&hi) || (~|hi)))
         sat = r[RW-1] ? Q_MIN : Q_MAX;
`ifdef CONV_ACC_RELU_EN
      res = sat[DWIDTH-1] ? '0 : sat;
`else
      res = sat;
`endif
   end
endmodule

// File: rtl/conv_mac_accumulator.sv
// Accumulates NTAPS products plus bias per kernel window, then rescales into
// a valid/ready output register. Build option CONV_ACC_RELU_EN (in acc_rescale_sat).
module conv_mac_accumulator
   import lenet_acc_pkg::*;
#(
   parameter int NTAPS = 25
) (
   input logic                   clk,
   input logic                   rst_n,
   conv_mac_accumulator_if.slave bus
);
   localparam int             CW   = clog2(NTAPS);
   localparam logic [CW-1:0]  LAST = CW'(NTAPS - 1);

   logic [CW-1:0]            tap_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W-1:0]  sum;
   logic [DWIDTH-1:0]        res;
   logic [DWIDTH-1:0]        dout_r;
   logic                     dout_valid_r;
   logic                     p_ready;
   logic                     accept;
   logic                     first;
   logic                     last;

   assign p_ready = !dout_valid_r || bus.dout_ready;
   assign accept  = bus.p_valid && p_ready;
   assign first   = (tap_cnt == '0);
   assign last    = (tap_cnt == LAST);

   // First tap seeds with the bias in Q2.30, dropping whatever acc held.
   assign acc_base = first ? {{(ACC_W-DWIDTH-FRAC){bus.bias_in[DWIDTH-1]}}, bus.bias_in, {FRAC{1'b0}}}
                           : acc;
   assign sum      = acc_base + {{(ACC_W-PWIDTH){bus.p_in[PWIDTH-1]}}, bus.p_in};

   acc_rescale_sat u_rescale (
      .sum (sum),
      .res (res)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc          <= '0;
         tap_cnt      <= '0;
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
      end else begin
         if (accept) begin
            acc     <= sum;
            tap_cnt <= last ? '0 : tap_cnt + 1'b1;
         end
         // A new result wins over a same-cycle drain, keeping valid high.
         if (accept && last) begin
            dout_r       <= res;
            dout_valid_r <= 1'b1;
         end else if (dout_valid_r && bus.dout_ready) begin
            dout_valid_r <= 1'b0;
         end
      end
   end

   assign bus.p_ready    = p_ready;
   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.busy       = (tap_cnt != '0);
endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Self-checking bench: fixed vectors, handshake corner cases and random
// windows against an arithmetic reference model.
module tb_conv_mac_accumulator;
   import lenet_acc_pkg::*;

`ifdef CONV_ACC_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_mac_accumulator_if bus ();
   conv_mac_accumulator_if bus1 ();

   conv_mac_accumulator #(.NTAPS(25)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   conv_mac_accumulator #(.NTAPS(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] bias;
      logic [31:0] tap;
      logic [15:0] exp;
   } vec_t;

   vec_t          vt[6];
   logic [31:0]   w1[25];
   logic [31:0]   w2[25];
   logic [15:0]   got_q[$];
   logic [15:0]   exp_q[$];
   bit            mon_en = 1'b0;
   bit            rnd_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Window result from the rules: floor(sum / 2^15), saturate, optional ReLU.
   function automatic logic [15:0] ref_out(input longint s);
      longint r;
      if (s >= 0) r = s / 32768;
      else        r = -((-s + 32767) / 32768);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      if (RELU && r < 0) r = 0;
      return 16'(r);
   endfunction

   function automatic logic [31:0] rand_tap();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v = {{10{v[21]}}, v[21:0]};
      return v;
   endfunction

   // Called shortly after a rising edge; returns 1 ns after the accepting edge.
   task automatic send_tap(input logic [31:0] p, input logic [15:0] b);
      int n;
      n = 0;
      if (rnd_rdy) bus.dout_ready = 1'($urandom_range(0, 1));
      bus.p_valid = 1'b1;
      bus.p_in    = p;
      bus.bias_in = b;
      #1;
      while (!bus.p_ready && n < 100) begin
         @(posedge clk); #1;
         if (rnd_rdy) bus.dout_ready = 1'b1;
         #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL tap_timeout: p_ready stayed %b for %0d cycles, required 1", bus.p_ready, n);
      end
      @(posedge clk); #1;
   endtask

   always @(negedge clk)
      if (mon_en && bus.dout_valid && bus.dout_ready) got_q.push_back(bus.dout);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint s1, s2, s;
      logic [15:0] b1, b2, b;
      logic [31:0] tp;

      vt[0] = '{bias: 16'h0100, tap: 32'h0000_8000, exp: 16'h0119};
      vt[1] = '{bias: 16'h0000, tap: 32'h3FFF_0000, exp: 16'h7FFF};
      vt[2] = '{bias: 16'h0000, tap: 32'hC000_0000, exp: RELU ? 16'h0000 : 16'h8000};
      vt[3] = '{bias: 16'h0000, tap: 32'h0000_8000, exp: 16'h0019};
      vt[4] = '{bias: 16'hFF00, tap: 32'h0000_0000, exp: RELU ? 16'h0000 : 16'hFF00};
      vt[5] = '{bias: 16'h0000, tap: 32'hFFFF_FFFF, exp: RELU ? 16'h0000 : 16'hFFFF};

      bus.p_valid = 0;  bus.p_in = 0;  bus.bias_in = 0;  bus.dout_ready = 1;
      bus1.p_valid = 0; bus1.p_in = 0; bus1.bias_in = 0; bus1.dout_ready = 1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dout", bus.dout, 16'h0000);
      check("rst_valid", bus.dout_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_p_ready", bus.p_ready, 1'b1);
      check("rst1_dout", bus1.dout, 16'h0000);
      check("rst1_valid", bus1.dout_valid, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // NTAPS=1: floor truncation, then back-to-back drain and reload
      bus1.p_valid = 1; bus1.p_in = 32'hFFFF_8CDD; bus1.bias_in = 16'h0000;
      @(posedge clk); #1;
      bus1.p_in = 32'h0001_0000; bus1.bias_in = 16'h0010;
      @(negedge clk);
      check("n1_trunc", bus1.dout, RELU ? 16'h0000 : 16'hFFFF);
      check("n1_valid", bus1.dout_valid, 1'b1);
      @(posedge clk); #1;
      bus1.p_valid = 0;
      @(negedge clk);
      check("n1_reload_dout", bus1.dout, 16'h0012);
      check("n1_reload_valid", bus1.dout_valid, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("n1_drained", bus1.dout_valid, 1'b0);

      // NTAPS=1 back pressure: second tap held until dout_ready
      @(posedge clk); #1;
      bus1.dout_ready = 0; bus1.p_valid = 1; bus1.p_in = 32'h7FFF_FFFF; bus1.bias_in = 16'h7FFF;
      @(posedge clk); #1;
      bus1.p_in = 32'h8000_0000; bus1.bias_in = 16'h8000;
      @(negedge clk);
      check("n1_sat_hi", bus1.dout, 16'h7FFF);
      check("n1_stall_ready", bus1.p_ready, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("n1_hold", bus1.dout, 16'h7FFF);
      @(posedge clk); #1;
      bus1.dout_ready = 1;
      @(posedge clk); #1;
      bus1.p_valid = 0;
      @(negedge clk);
      check("n1_sat_lo", bus1.dout, RELU ? 16'h0000 : 16'h8000);
      check("n1_sat_lo_valid", bus1.dout_valid, 1'b1);
      @(posedge clk); #1;

      // Fixed windows, NTAPS=25; bias on later taps must be ignored
      for (int i = 0; i < 6; i++) begin
         for (int t = 0; t < 25; t++) begin
            send_tap(vt[i].tap, (t == 0) ? vt[i].bias : 16'($urandom));
            if (t == 0) begin
               @(negedge clk);
               check("vec_busy", bus.busy, 1'b1);
            end
         end
         bus.p_valid = 0;
         @(negedge clk);
         check("vec_dout", bus.dout, vt[i].exp);
         check("vec_valid", bus.dout_valid, 1'b1);
         check("vec_idle", bus.busy, 1'b0);
         @(posedge clk); #1;
         @(negedge clk);
         check("vec_one_cycle", bus.dout_valid, 1'b0);
         @(posedge clk); #1;
      end

      // Back pressure across windows: held tap not counted, nothing lost
      b1 = 16'($urandom); b2 = 16'($urandom);
      s1 = longint'($signed(b1)) * 32768;
      s2 = longint'($signed(b2)) * 32768;
      for (int t = 0; t < 25; t++) begin
         w1[t] = rand_tap(); w2[t] = rand_tap();
         s1 += longint'($signed(w1[t]));
         s2 += longint'($signed(w2[t]));
      end
      bus.dout_ready = 0;
      for (int t = 0; t < 25; t++) send_tap(w1[t], b1);
      bus.p_valid = 1; bus.p_in = w2[0]; bus.bias_in = b2;
      @(negedge clk);
      check("bp_p_ready", bus.p_ready, 1'b0);
      check("bp_dout1", bus.dout, ref_out(s1));
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("bp_nocount", bus.busy, 1'b0);
      check("bp_still_valid", bus.dout_valid, 1'b1);
      @(posedge clk); #1;
      bus.dout_ready = 1;
      for (int t = 0; t < 25; t++) send_tap(w2[t], (t == 0) ? b2 : 16'($urandom));
      bus.p_valid = 0;
      @(negedge clk);
      check("bp_dout2", bus.dout, ref_out(s2));
      check("bp_valid2", bus.dout_valid, 1'b1);
      @(posedge clk); #1;

      // Reset in mid-window drops the partial sum
      for (int t = 0; t < 10; t++) send_tap(rand_tap(), 16'h1234);
      bus.p_valid = 0;
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_valid", bus.dout_valid, 1'b0);
      @(posedge clk); #1;
      for (int t = 0; t < 25; t++) send_tap(32'h0000_8000, 16'h0000);
      bus.p_valid = 0;
      @(negedge clk);
      check("post_rst_dout", bus.dout, 16'h0019);
      @(posedge clk); #1;

      // Random windows with gaps and random dout_ready
      mon_en = 1; rnd_rdy = 1;
      for (int w = 0; w < 30; w++) begin
         b = 16'($urandom);
         s = longint'($signed(b)) * 32768;
         for (int t = 0; t < 25; t++) begin
            tp = rand_tap();
            s += longint'($signed(tp));
            if ($urandom_range(0, 3) == 0) begin
               bus.p_valid = 0;
               @(posedge clk); #1;
            end
            send_tap(tp, (t == 0) ? b : 16'($urandom));
         end
         exp_q.push_back(ref_out(s));
      end
      bus.p_valid = 0; rnd_rdy = 0; bus.dout_ready = 1;
      repeat (4) @(posedge clk);
      #1;
      mon_en = 0;
      check("rnd_count", got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check("rnd_dout", got_q.pop_front(), exp_q.pop_front());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv_mac_accumulator.md
# conv_mac_accumulator

Accumulates the signed 32-bit products from the convolution multiplier over one kernel window, adds a per-window bias, and rescales, rounds and saturates the sum back to the 16-bit fixed-point activation format. It sits directly downstream of the multiplier IP, whose product feeds it once per accepted tap. It drives the pooling/feature-map write stage through a valid/ready output register.

## Interface
- DWIDTH, 16: activation/weight/bias/output width, signed Q1.15.
- PWIDTH, 32: product width from multiplier (2*DWIDTH), signed Q2.30.
- ACC_W, 40: accumulator width (PWIDTH + 8 guard bits).
- NTAPS, 25: products per window (5x5 kernel); legal range 1..255.
- FRAC, 15: fractional bits dropped when rescaling.
---
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- p_in  in  PWIDTH  signed product from multiplier.
- p_valid  in  1  p_in carries a valid tap this cycle.
- p_ready  out  1  block accepts a tap this cycle; upstream drives the multiplier CE from it.
- bias_in  in  DWIDTH  signed Q1.15 bias; sampled with the first tap of each window.
- dout  out  DWIDTH  signed Q1.15 window result.
- dout_valid  out  1  dout holds a result.
- dout_ready  in  1  downstream consumes dout.
- busy  out  1  a window is partially accumulated (tap_cnt != 0).

## Operation
- Tap accept: p_valid && p_ready.
- p_ready = !dout_valid || dout_ready. Taps are accepted while the output register is free or draining.
- tap_cnt counts 0..NTAPS-1 and wraps to 0 after the last tap.
- First tap (tap_cnt==0): acc <= sign_ext(bias_in) <<< FRAC + sign_ext(p_in). This discards any previous acc.
- Other taps: acc <= acc + sign_ext(p_in). Arithmetic is two's complement on ACC_W bits, with no internal wrap for legal NTAPS.
- Last tap (tap_cnt==NTAPS-1): the final sum (acc + p_in) is rescaled into dout and dout_valid is set.
- Rescale: r = final_sum >>> FRAC (arithmetic shift, truncation toward −inf, matching bits [30:15] of the product). This is bit-exact with the multiplier slicing.
- Saturate: r > 0x7FFF gives 0x7FFF; r < −0x8000 gives 0x8000; otherwise r[15:0].
- Output register: dout_valid clears on dout_valid && dout_ready, unless a new last tap loads it in the same cycle, in which case it stays set with the new dout.
- Reset: acc=0, tap_cnt=0, dout=0, dout_valid=0, busy=0. A reset in mid-window drops the partial sum, and no output is produced for that window.
- p_in and bias_in are ignored when p_valid is low. When p_ready is low, held taps are not counted.

## Timing
- Latency: dout_valid rises 1 cycle after the clock edge that accepts the last tap.
- Throughput: 1 tap/cycle. Back-to-back windows run with no bubble while dout_ready=1.
- Stall: with dout_valid=1 and dout_ready=0, p_ready=0 on the same cycle (combinational). Upstream must freeze the multiplier via CE.
- The multiplier pipeline delay is upstream's responsibility. p_valid must be aligned with P.

## Configuration
- CONV_ACC_RELU_EN defined: after saturation, a negative result is forced to 0x0000, so dout lies in 0x0000..0x7FFF.
- Not defined: the signed saturated result is passed unchanged.
- Latency and handshake are identical in both builds.

## Structure
- Shared package lenet_acc_pkg holds:
  - DWIDTH, PWIDTH, ACC_W, FRAC
  - Q-format limit constants: Q_MAX=16'h7FFF, Q_MIN=16'h8000
  - the tap-counter width function clog2(NTAPS)
- One sub-module, acc_rescale_sat: purely combinational. It takes the ACC_W sum, applies the FRAC shift and saturation, and applies the optional ReLU. It is reused by the fully-connected layer.
- The top level holds the counter, accumulator and output register.

## Test plan
- NTAPS=1, bias 0, p_in=0xFFFF8CDD (0x00E1 × 0xFF7D) → dout=0xFFFF 1 cycle later. With CONV_ACC_RELU_EN, dout=0x0000.
- NTAPS=25, bias 0x0100, 25 taps of 0x00008000 → dout=0x0119, dout_valid high for exactly one cycle with dout_ready=1.
- NTAPS=25, 25 taps of 0x3FFF0000 → dout=0x7FFF. 25 taps of 0xC0000000 → dout=0x8000 (ReLU build: 0x0000).
- Back pressure: hold dout_ready=0 after window 1 completes → p_ready=0 and window-2 taps are not counted. Release → window 2 result is correct and no tap is lost.
- Simultaneous drain and load: dout_ready=1 on the same cycle window 2's last tap is accepted → dout_valid stays 1 and dout updates to result 2.
- Reset after tap 10 of 25, then a full window with bias 0 and 25 taps of 0x00008000 → dout=0x0019. busy=0 right after reset.
